mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the data memory (slave).
// The memory raises ready for one cycle when the access completes; rdata is valid in that cycle.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass through in one cycle, loads and stores stall the
// pipeline until the data memory answers or the wait budget runs out (sticky mem_err).
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_pc,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_write_reg,
  input  logic        ex_write_en,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic        wb_write_en,
  output logic        wb_mem_read,
  output logic [15:0] wb_pc,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output logic [2:0]  wb_write_reg,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [15:0] op_pc;
  logic [31:0] op_alu_res;
  logic [31:0] op_store_data;
  logic [2:0]  op_write_reg;
  logic        op_write_en;
  logic        op_store;
  logic        is_mem_op;
  logic        accept_alu;
  logic        accept_mem;
  logic        access_timeout;

  assign is_mem_op      = ex_mem_read | ex_mem_write;
  assign accept_alu     = (state == IDLE) && ex_valid && !is_mem_op;
  assign accept_mem     = (state == IDLE) && ex_valid && is_mem_op;
  assign access_timeout = (state == ACCESS) && !dmem.ready && (wait_cnt == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_mem) state_next = ACCESS;
      ACCESS:  if (dmem.ready || access_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The bus is driven from the latched op, so it stays stable for the whole access.
  always_comb begin
    stall      = (state == ACCESS);
    dmem.req   = (state == ACCESS);
    dmem.we    = (state == ACCESS) && op_store;
    dmem.addr  = op_alu_res[15:0];
    dmem.wdata = op_store_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      op_pc         <= '0;
      op_alu_res    <= '0;
      op_store_data <= '0;
      op_write_reg  <= '0;
      op_write_en   <= 1'b0;
      op_store      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_write_en   <= 1'b0;
      wb_mem_read   <= 1'b0;
      wb_pc         <= '0;
      wb_alu_res    <= '0;
      wb_mem_data   <= '0;
      wb_write_reg  <= '0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid <= accept_alu;
          if (accept_alu) begin
            wb_write_en  <= ex_write_en;
            wb_mem_read  <= 1'b0;
            wb_pc        <= ex_pc;
            wb_alu_res   <= ex_alu_res;
            wb_write_reg <= ex_write_reg;
          end else begin
            wb_write_en <= 1'b0;
          end
          if (accept_mem) begin
            op_pc         <= ex_pc;
            op_alu_res    <= ex_alu_res;
            op_store_data <= ex_store_data;
            op_write_reg  <= ex_write_reg;
            op_write_en   <= ex_write_en;
            op_store      <= ex_mem_write;  // read+write together behaves as a store
            wait_cnt      <= '0;
          end
        end
        ACCESS: begin
          if (dmem.ready) begin
            wb_valid     <= 1'b1;
            wb_write_en  <= op_write_en;
            wb_mem_read  <= !op_store;
            wb_pc        <= op_pc;
            wb_alu_res   <= op_alu_res;
            wb_write_reg <= op_write_reg;
            if (!op_store) wb_mem_data <= dmem.rdata;
          end else if (wait_cnt == LAST_WAIT) begin
            wb_valid     <= 1'b1;
            wb_write_en  <= 1'b0;
            wb_mem_read  <= 1'b0;
            wb_pc        <= op_pc;
            wb_alu_res   <= op_alu_res;
            wb_write_reg <= op_write_reg;
            mem_err      <= 1'b1;
          end else begin
            wb_valid <= 1'b0;
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a transaction-level model predicts each op's stall length
// and write-back result; the bench also acts as the data memory with a chosen latency.
module tb_mem_stage;
  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_write_reg;
  logic        ex_write_en;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        stall;
  logic        wb_valid;
  logic        wb_write_en;
  logic        wb_mem_read;
  logic [15:0] wb_pc;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_data;
  logic [2:0]  wb_write_reg;
  logic        mem_err;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_alu_res    (ex_alu_res),
    .ex_store_data (ex_store_data),
    .ex_write_reg  (ex_write_reg),
    .ex_write_en   (ex_write_en),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .stall         (stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_write_en   (wb_write_en),
    .wb_mem_read   (wb_mem_read),
    .wb_pc         (wb_pc),
    .wb_alu_res    (wb_alu_res),
    .wb_mem_data   (wb_mem_data),
    .wb_write_reg  (wb_write_reg),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected architecturally visible write-back state.
  logic [15:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_md;
  logic [2:0]  m_reg;
  logic        m_mr;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [15:0] pc, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [2:0] wreg, input logic wen,
                          input logic rd, input logic wr);
    ex_valid      = v;
    ex_pc         = pc;
    ex_alu_res    = alu;
    ex_store_data = sd;
    ex_write_reg  = wreg;
    ex_write_en   = wen;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, 16'($urandom), $urandom, $urandom, 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
  endtask

  task automatic check_wb(input string tag, input logic v, input logic wen);
    check({tag, "/wb_valid"},     wb_valid,     v);
    check({tag, "/wb_write_en"},  wb_write_en,  wen);
    check({tag, "/wb_mem_read"},  wb_mem_read,  m_mr);
    check({tag, "/wb_pc"},        wb_pc,        m_pc);
    check({tag, "/wb_alu_res"},   wb_alu_res,   m_alu);
    check({tag, "/wb_write_reg"}, wb_write_reg, m_reg);
    check({tag, "/wb_mem_data"},  wb_mem_data,  m_md);
    check({tag, "/stall"},        stall,        1'b0);
    check({tag, "/dmem_req"},     dmem.req,     1'b0);
    check({tag, "/dmem_we"},      dmem.we,      1'b0);
    check({tag, "/mem_err"},      mem_err,      m_err);
  endtask

  // Reset is applied with random upstream and memory activity, which it must override.
  task automatic apply_reset();
    rst = 1'b1;
    drive_ex(1'b1, 16'($urandom), $urandom, $urandom, 3'($urandom), 1'b1, 1'($urandom), 1'b0);
    dmem.ready = 1'b1;
    dmem.rdata = $urandom;
    step();
    rst = 1'b0;
    drive_idle();
    dmem.ready = 1'b0;
    m_pc = '0; m_alu = '0; m_md = '0; m_reg = '0; m_mr = 1'b0; m_err = 1'b0;
    check_wb("reset", 1'b0, 1'b0);
    check("reset/dmem_addr",  dmem.addr,  32'h0);
    check("reset/dmem_wdata", dmem.wdata, 32'h0);
  endtask

  task automatic do_alu(input logic [15:0] pc, input logic [31:0] alu, input logic [2:0] wreg,
                        input logic wen);
    drive_ex(1'b1, pc, alu, $urandom, wreg, wen, 1'b0, 1'b0);
    dmem.ready = 1'($urandom);  // ignored while no access is pending
    dmem.rdata = $urandom;
    check("alu/stall_before", stall, 1'b0);
    step();
    m_pc = pc; m_alu = alu; m_reg = wreg; m_mr = 1'b0;
    check_wb("alu", 1'b1, wen);
  endtask

  task automatic do_bubble();
    drive_idle();
    dmem.ready = 1'($urandom);
    dmem.rdata = $urandom;
    step();
    check_wb("bubble", 1'b0, 1'b0);
  endtask

  // d = wait cycles before ready; d >= TIMEOUT means the memory never answers.
  task automatic do_mem(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [2:0] wreg, input logic wen,
                        input int d, input logic [31:0] rdata, input bit next_alu);
    logic        store;
    bit          timed_out;
    int          n;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [31:0] nalu;
    logic [2:0]  nreg;
    logic        nwe;
    store     = wr;
    timed_out = (d >= int'(TIMEOUT));
    n         = timed_out ? int'(TIMEOUT) : d + 1;
    pc        = 16'($urandom);
    npc       = 16'($urandom);
    nalu      = $urandom;
    nreg      = 3'($urandom);
    nwe       = 1'($urandom);
    drive_ex(1'b1, pc, alu, sd, wreg, wen, rd, wr);
    dmem.ready = 1'($urandom);
    dmem.rdata = $urandom;
    check("mem/stall_before", stall, 1'b0);
    step();
    if (next_alu) drive_ex(1'b1, npc, nalu, $urandom, nreg, nwe, 1'b0, 1'b0);
    else          drive_idle();
    for (int k = 0; k < n; k++) begin
      check("acc/stall",    stall,      1'b1);
      check("acc/req",      dmem.req,   1'b1);
      check("acc/we",       dmem.we,    store);
      check("acc/addr",     dmem.addr,  {16'h0, alu[15:0]});
      check("acc/wdata",    dmem.wdata, sd);
      check("acc/wb_valid", wb_valid,   1'b0);
      dmem.ready = (k == d);
      dmem.rdata = (k == d) ? rdata : $urandom;
      step();
    end
    dmem.ready = 1'($urandom);
    dmem.rdata = $urandom;
    if (timed_out) begin
      m_err = 1'b1;
      check("tmo/wb_valid",    wb_valid,    1'b1);
      check("tmo/wb_write_en", wb_write_en, 1'b0);
      check("tmo/mem_err",     mem_err,     1'b1);
      check("tmo/stall",       stall,       1'b0);
      check("tmo/dmem_req",    dmem.req,    1'b0);
    end else begin
      m_pc = pc; m_alu = alu; m_reg = wreg; m_mr = !store;
      if (!store) m_md = rdata;
      check_wb("mem_done", 1'b1, wen);
      if (next_alu) begin
        step();
        m_pc = npc; m_alu = nalu; m_reg = nreg; m_mr = 1'b0;
        check_wb("alu_after_mem", 1'b1, nwe);
      end
    end
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    drive_idle();
    dmem.ready = 1'b0;
    dmem.rdata = '0;
    apply_reset();

    do_alu(16'h0010, 32'h0000_0005, 3'd3, 1'b1);
    do_mem(1'b1, 1'b0, 32'h0000_0040, $urandom, 3'd1, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
    do_mem(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 3'd2, 1'b0, 0, $urandom, 1'b0);
    do_mem(1'b1, 1'b1, $urandom, $urandom, 3'd4, 1'b1, 1, $urandom, 1'b0);
    do_mem(1'b1, 1'b0, $urandom, $urandom, 3'd5, 1'b1, 2, $urandom, 1'b1);
    do_bubble();

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: do_alu(16'($urandom), $urandom, 3'($urandom), 1'($urandom));
        1: do_mem(1'b1, 1'b0, $urandom, $urandom, 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, TIMEOUT - 1)), $urandom, 1'($urandom));
        2: do_mem(1'b0, 1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, TIMEOUT - 1)), $urandom, 1'($urandom));
        3: do_mem(1'b1, 1'b1, $urandom, $urandom, 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, TIMEOUT - 1)), $urandom, 1'($urandom));
        default: do_bubble();
      endcase
    end

    // Memory never answers: abort after TIMEOUT access cycles, error stays until reset.
    do_mem(1'b1, 1'b0, $urandom, $urandom, 3'd6, 1'b1, int'(TIMEOUT) + 10, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      step();
      check("tmo_hold/mem_err",  mem_err,  1'b1);
      check("tmo_hold/wb_valid", wb_valid, 1'b0);
    end
    apply_reset();

    // Reset in the second access cycle of a load aborts it without a write-back pulse.
    drive_ex(1'b1, 16'h0100, 32'h0000_0080, $urandom, 3'd7, 1'b1, 1'b1, 1'b0);
    dmem.ready = 1'b0;
    step();
    drive_idle();
    check("abort/req_c0", dmem.req, 1'b1);
    step();
    check("abort/req_c1", dmem.req, 1'b1);
    apply_reset();
    for (int i = 0; i < 3; i++) do_bubble();
    do_alu(16'($urandom), $urandom, 3'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
